// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF-stage program counter with exception/ERET/redirect selection and stall-time redirect buffering
module pc_fetch_unit #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'h0000_4180,
  parameter logic [ADDR_W-1:0] IM_LO        = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] IM_HI        = 32'h0000_6FFF,
  parameter int                CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_adel,
  output logic              redirected,
  output logic              pend_valid,
  output logic [CNT_W-1:0]  fetch_count
);
  typedef enum logic {IDLE, PEND} pend_state_e;
  pend_state_e       state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pend_target_q, pend_target_d;
  logic              redirected_q, redirected_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;
  logic              hold, take_redirect, take_pend;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      state_q       <= IDLE;
      pend_target_q <= '0;
      redirected_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
      redirected_q  <= redirected_d;
      fetch_count_q <= fetch_count_d;
    end
  end
  always_comb begin
    hold          = stall && !req && !eret;
    take_redirect = redirect_valid && !stall;
    take_pend     = (state_q == PEND) && !stall;
    pc_d          = req ? EXC_VECTOR :
                    eret ? epc :
                    take_redirect ? redirect_target :
                    stall ? pc_q :
                    take_pend ? pend_target_q : pc_plus4;
    redirected_d  = req || eret || take_redirect || take_pend;
    fetch_count_d = fetch_count_q + CNT_W'(!hold);
    state_d       = (req || eret) ? IDLE :
                    (redirect_valid && stall) ? PEND :
                    !stall ? IDLE : state_q;
    pend_target_d = (hold && redirect_valid) ? redirect_target : pend_target_q;
  end
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + ADDR_W'(4);
  assign fetch_adel  = (|pc_q[1:0]) || (pc_q < IM_LO) || (pc_q > IM_HI);
  assign redirected  = redirected_q;
  assign pend_valid  = (state_q == PEND);
  assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench for pc_fetch_unit; expected outputs are queued as stimulus is driven
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, req, eret, redirect_valid, stall;
  logic [31:0] epc, redirect_target;
  logic [31:0] pc, pc_plus4, fetch_count;
  logic        fetch_adel, redirected, pend_valid;
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        rd;
    logic        pv;
    logic [31:0] cnt;
    logic        adel;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .req(req), .eret(eret), .epc(epc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .stall(stall),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_adel(fetch_adel), .redirected(redirected),
    .pend_valid(pend_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t x(input logic [31:0] p, input logic rd, input logic pv, input logic [31:0] c, input logic a);
    return {p, rd, pv, c, a};
  endfunction

  function automatic exp_t obs();
    return {pc, redirected, pend_valid, fetch_count, fetch_adel};
  endfunction

  function automatic string fmt(input exp_t v);
    return $sformatf("pc=%h rd=%b pv=%b cnt=%0d adel=%b", v.pc, v.rd, v.pv, v.cnt, v.adel);
  endfunction

  task automatic drive(input logic r, input logic q, input logic er, input logic [31:0] ep,
                       input logic v, input logic [31:0] t, input logic s, input exp_t ex);
    reset = r; req = q; eret = er; epc = ep; redirect_valid = v; redirect_target = t; stall = s;
    sb.push_back(ex);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, x(32'h3000, 0, 0, 0, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL reset got %s exp %s", fmt(obs()), fmt(e)); end
    total++; if (pc_plus4 !== 32'h3004) begin bad++; $display("FAIL reset_plus4 got %h exp 00003004", pc_plus4); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, x(32'h3000 + 32'(4 * i), 0, 0, 32'(i), 0));
      e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL seq%0d got %s exp %s", i, fmt(obs()), fmt(e)); end
    end
  endtask

  task automatic test_stall_redirect();
    drive(0, 0, 0, 0, 1, 32'h3100, 1, x(32'h3010, 0, 1, 4, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL stall_buf got %s exp %s", fmt(obs()), fmt(e)); end
    drive(0, 0, 0, 0, 0, 32'h0, 1, x(32'h3010, 0, 1, 4, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL stall_hold got %s exp %s", fmt(obs()), fmt(e)); end
    drive(0, 0, 0, 0, 0, 32'h0, 0, x(32'h3100, 1, 0, 5, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL stall_release got %s exp %s", fmt(obs()), fmt(e)); end
    drive(0, 0, 0, 0, 0, 32'h0, 0, x(32'h3104, 0, 0, 6, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL after_release got %s exp %s", fmt(obs()), fmt(e)); end
  endtask

  task automatic test_req_stall();
    drive(0, 0, 0, 0, 1, 32'h3200, 1, x(32'h3104, 0, 1, 6, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL req_prep got %s exp %s", fmt(obs()), fmt(e)); end
    drive(0, 1, 0, 0, 0, 32'h0, 1, x(32'h4180, 1, 0, 7, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL req_stall got %s exp %s", fmt(obs()), fmt(e)); end
  endtask

  task automatic test_req_eret();
    drive(0, 1, 1, 32'h3020, 0, 32'h0, 0, x(32'h4180, 1, 0, 8, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL req_over_eret got %s exp %s", fmt(obs()), fmt(e)); end
    drive(0, 0, 1, 32'h3020, 0, 32'h0, 0, x(32'h3020, 1, 0, 9, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL eret got %s exp %s", fmt(obs()), fmt(e)); end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 0, 1, 32'h3300, 1, x(32'h3020, 0, 1, 9, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL b2b_buf got %s exp %s", fmt(obs()), fmt(e)); end
    drive(0, 0, 0, 0, 1, 32'h3400, 0, x(32'h3400, 1, 0, 10, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL b2b_new_wins got %s exp %s", fmt(obs()), fmt(e)); end
  endtask

  task automatic test_adel();
    drive(0, 0, 1, 32'h3022, 0, 32'h0, 0, x(32'h3022, 1, 0, 11, 1));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL adel_misalign got %s exp %s", fmt(obs()), fmt(e)); end
    drive(0, 0, 0, 0, 1, 32'h7000, 0, x(32'h7000, 1, 0, 12, 1));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL adel_above got %s exp %s", fmt(obs()), fmt(e)); end
    drive(0, 0, 0, 0, 1, 32'h6FFC, 0, x(32'h6FFC, 1, 0, 13, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL adel_top_ok got %s exp %s", fmt(obs()), fmt(e)); end
    drive(0, 0, 0, 0, 1, 32'h2FFC, 0, x(32'h2FFC, 1, 0, 14, 1));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL adel_below got %s exp %s", fmt(obs()), fmt(e)); end
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, x(32'hFFFF_FFFC, 1, 0, 15, 1));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL wrap_prep got %s exp %s", fmt(obs()), fmt(e)); end
    total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_plus4 got %h exp 00000000", pc_plus4); end
    drive(0, 0, 0, 0, 0, 32'h0, 0, x(32'h0, 0, 0, 16, 1));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL wrap_seq got %s exp %s", fmt(obs()), fmt(e)); end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 32'h0, 0, x(32'h3000, 0, 0, 0, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL rm_reset got %s exp %s", fmt(obs()), fmt(e)); end
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 0, 0, 32'h0, 0, x(32'h3000 + 32'(4 * i), 0, 0, 32'(i), 0));
      e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL rm_seq%0d got %s exp %s", i, fmt(obs()), fmt(e)); end
    end
    drive(0, 0, 0, 0, 1, 32'h3500, 1, x(32'h3014, 0, 1, 5, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL rm_buf got %s exp %s", fmt(obs()), fmt(e)); end
    drive(1, 0, 0, 0, 0, 32'h0, 1, x(32'h3000, 0, 0, 0, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL rm_mid_reset got %s exp %s", fmt(obs()), fmt(e)); end
    drive(0, 0, 0, 0, 0, 32'h0, 0, x(32'h3004, 0, 0, 1, 0));
    e = sb.pop_front(); total++; if (obs() !== e) begin bad++; $display("FAIL rm_after got %s exp %s", fmt(obs()), fmt(e)); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_req_stall();
    test_req_eret();
    test_back_to_back();
    test_adel();
    test_reset_mid();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got %0d exp 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
